// File: rtl/basket_controller_if.sv
// Command handshake between the sale-terminal state machine and the basket controller.
interface basket_controller_if;
  logic       ENABLE;
  logic [1:0] CMD;
  logic [3:0] ProductID;
  logic [3:0] ProductQuantity;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [1:0] ErrorCode;

  modport master (
    output ENABLE, CMD, ProductID, ProductQuantity,
    input  Busy, Done, Error, ErrorCode
  );

  modport slave (
    input  ENABLE, CMD, ProductID, ProductQuantity,
    output Busy, Done, Error, ErrorCode
  );
endinterface

// File: rtl/basket_controller.sv
// Basket storage sequencer: scans slots for a product, fetches its unit price from a
// registered ROM and updates the slot array and the saturating running total.
module basket_controller #(
  parameter int SLOTS        = 8,
  parameter int NUM_PRODUCTS = 12,
  parameter int PRICE_W      = 8,
  parameter int TOTAL_W      = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  basket_controller_if.slave bus,
  output logic [3:0]         PriceAddr,
  input  logic [PRICE_W-1:0] PriceData,
  output logic [3:0]         ItemCount,
  output logic               BasketFull,
  output logic [TOTAL_W-1:0] TotalPrice,
  input  logic [2:0]         RdIndex,
  output logic [3:0]         RdID,
  output logic [3:0]         RdQty
);

  localparam int           IW      = $clog2(SLOTS);
  localparam int           PW      = PRICE_W + 4;
  localparam logic [3:0]   NP_C    = 4'(NUM_PRODUCTS);
  localparam logic [3:0]   SLOTS_C = 4'(SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, PRICE, ACCUM} state_t;
  typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_REM = 2'b01, CMD_CLR = 2'b10, CMD_RSV = 2'b11} cmd_t;

  state_t             r_state;
  cmd_t               r_cmd;
  logic [3:0]         r_id;
  logic [3:0]         r_qty;
  logic [3:0]         r_idx;
  logic [IW-1:0]      r_match;
  logic               r_found;
  logic [3:0]         r_count;
  logic [TOTAL_W-1:0] r_total;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [1:0]         r_ecode;
  logic [3:0]         r_paddr;
  logic [3:0]         r_slot_id  [SLOTS];
  logic [3:0]         r_slot_qty [SLOTS];

  logic               w_invalid;
  logic [IW-1:0]      w_last;
  logic [3:0]         w_old_qty;
  logic [4:0]         w_qty_sum;
  logic [3:0]         w_new_qty;
  logic [3:0]         w_mul_qty;
  logic [PW-1:0]      w_prod;
  logic [TOTAL_W:0]   w_sum;
  logic [TOTAL_W-1:0] w_total_add;
  logic [TOTAL_W-1:0] w_total_sub;
  logic               w_rd_ok;

  always_comb begin
    w_invalid = 1'b0;
    if (bus.CMD == CMD_RSV)
      w_invalid = 1'b1;
    else if (bus.CMD == CMD_ADD)
      w_invalid = (bus.ProductID >= NP_C) || (bus.ProductQuantity == 4'd0);
    else if (bus.CMD == CMD_REM)
      w_invalid = (bus.ProductID >= NP_C);
  end

  // A full basket wraps the low count bits to 0, so minus one still lands on the last slot.
  assign w_last    = r_count[IW-1:0] - IW'(1);
  assign w_old_qty = r_slot_qty[r_match];
  assign w_qty_sum = {1'b0, w_old_qty} + {1'b0, r_qty};
  assign w_new_qty = w_qty_sum[4] ? 4'hF : w_qty_sum[3:0];

  always_comb begin
    w_mul_qty = r_qty;
    if (r_cmd == CMD_REM)
      w_mul_qty = w_old_qty;
    else if (r_found)
      w_mul_qty = w_new_qty - w_old_qty;
  end

  assign w_prod      = PW'(w_mul_qty) * PW'(PriceData);
  assign w_sum       = {1'b0, r_total} + (TOTAL_W+1)'(w_prod);
  assign w_total_add = w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
  assign w_total_sub = (r_total >= TOTAL_W'(w_prod)) ? (r_total - TOTAL_W'(w_prod)) : '0;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cmd   <= CMD_ADD;
      r_id    <= '0;
      r_qty   <= '0;
      r_idx   <= '0;
      r_match <= '0;
      r_found <= 1'b0;
      r_count <= '0;
      r_total <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_ecode <= '0;
      r_paddr <= '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
        r_slot_id[k]  <= '0;
        r_slot_qty[k] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ENABLE) begin
            r_cmd   <= cmd_t'(bus.CMD);
            r_id    <= bus.ProductID;
            r_qty   <= bus.ProductQuantity;
            r_paddr <= bus.ProductID;
            r_ecode <= 2'b00;
            r_idx   <= '0;
            r_found <= 1'b0;
            if (w_invalid) begin
              r_error <= 1'b1;
              r_ecode <= 2'b01;
            end else if (bus.CMD == CMD_CLR) begin
              r_count <= '0;
              r_total <= '0;
              r_done  <= 1'b1;
              for (int unsigned k = 0; k < SLOTS; k++) begin
                r_slot_id[k]  <= '0;
                r_slot_qty[k] <= '0;
              end
            end else begin
              r_busy  <= 1'b1;
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (r_idx == r_count) begin
            if (r_cmd == CMD_ADD && r_count < SLOTS_C) begin
              r_state <= PRICE;
            end else begin
              r_error <= 1'b1;
              r_ecode <= (r_cmd == CMD_ADD) ? 2'b10 : 2'b11;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else if (r_slot_id[r_idx[IW-1:0]] == r_id) begin
            r_found <= 1'b1;
            r_match <= r_idx[IW-1:0];
            r_state <= PRICE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        PRICE: r_state <= ACCUM;
        ACCUM: begin
          if (r_cmd == CMD_ADD) begin
            r_total <= w_total_add;
            if (r_found) begin
              r_slot_qty[r_match] <= w_new_qty;
            end else begin
              r_slot_id[r_count[IW-1:0]]  <= r_id;
              r_slot_qty[r_count[IW-1:0]] <= r_qty;
              r_count                     <= r_count + 4'd1;
            end
          end else begin
            // Later assignment zeroes the slot when the match was already the last one.
            r_total             <= w_total_sub;
            r_slot_id[r_match]  <= r_slot_id[w_last];
            r_slot_qty[r_match] <= r_slot_qty[w_last];
            r_slot_id[w_last]   <= '0;
            r_slot_qty[w_last]  <= '0;
            r_count             <= r_count - 4'd1;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_ok = ({1'b0, RdIndex} < r_count);

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.Error     = r_error;
  assign bus.ErrorCode = r_ecode;
  assign PriceAddr     = r_paddr;
  assign ItemCount     = r_count;
  assign BasketFull    = (r_count == SLOTS_C);
  assign TotalPrice    = r_total;
  assign RdID          = w_rd_ok ? r_slot_id[RdIndex]  : 4'd0;
  assign RdQty         = w_rd_ok ? r_slot_qty[RdIndex] : 4'd0;

endmodule

// File: tb/tb_basket_controller.sv
// Directed plus randomized checks of basket_controller against a queue-based basket model.
`timescale 1ns/1ps
module tb_basket_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  price_addr;
  logic [7:0]  price_data = '0;
  logic [3:0]  item_count;
  logic        basket_full;
  logic [15:0] total_price;
  logic [2:0]  rd_index = '0;
  logic [3:0]  rd_id;
  logic [3:0]  rd_qty;

  basket_controller_if bus();

  basket_controller #(.SLOTS(8), .NUM_PRODUCTS(12), .PRICE_W(8), .TOTAL_W(16)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .bus        (bus),
    .PriceAddr  (price_addr),
    .PriceData  (price_data),
    .ItemCount  (item_count),
    .BasketFull (basket_full),
    .TotalPrice (total_price),
    .RdIndex    (rd_index),
    .RdID       (rd_id),
    .RdQty      (rd_qty)
  );

  always #5 clk = ~clk;

  // Registered price ROM: price = 10*(ID+1)
  always @(posedge clk) price_data <= 8'((int'(price_addr) + 1) * 10);

  typedef struct { int id; int qty; } ent_t;
  ent_t model[$];
  int   m_total = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_view(input string tag);
    check_eq({tag, ".count"}, int'(item_count), model.size());
    check_eq({tag, ".total"}, int'(total_price), m_total);
    check_eq({tag, ".full"}, int'(basket_full), (model.size() == 8) ? 1 : 0);
    for (int j = 0; j < 8; j++) begin
      rd_index = 3'(j);
      #1;
      check_eq($sformatf("%s.rdid%0d", tag, j), int'(rd_id), (j < model.size()) ? model[j].id : 0);
      check_eq($sformatf("%s.rdqty%0d", tag, j), int'(rd_qty), (j < model.size()) ? model[j].qty : 0);
    end
  endtask

  // Issue one command, predict its outcome from the basket rules, then check timing and state.
  task automatic run_cmd(input string tag, input int cmd, input int id, input int qty, input bit poke);
    int n, m, lat, kind, code, price, nq, got_k, extra;
    n = model.size();
    m = -1;
    for (int i = 0; i < n; i++) if (model[i].id == id) m = i;
    price = 10 * (id + 1);
    code = 0;
    kind = 1;
    if (cmd == 3 || (cmd == 0 && (id >= 12 || qty == 0)) || (cmd == 1 && id >= 12)) begin
      lat = 1; kind = 2; code = 1;
    end else if (cmd == 2) begin
      lat = 1; model.delete(); m_total = 0;
    end else if (cmd == 0) begin
      if (m >= 0) begin
        lat = m + 4;
        nq = (model[m].qty + qty > 15) ? 15 : model[m].qty + qty;
        m_total = m_total + (nq - model[m].qty) * price;
        model[m].qty = nq;
      end else if (n < 8) begin
        lat = n + 4;
        model.push_back('{id: id, qty: qty});
        m_total = m_total + qty * price;
      end else begin
        lat = n + 2; kind = 2; code = 2;
      end
      if (m_total > 65535) m_total = 65535;
    end else begin
      if (m >= 0) begin
        lat = m + 4;
        m_total = m_total - model[m].qty * price;
        if (m_total < 0) m_total = 0;
        model[m] = model[model.size() - 1];
        void'(model.pop_back());
      end else begin
        lat = n + 2; kind = 2; code = 3;
      end
    end

    @(negedge clk);
    bus.ENABLE = 1'b1;
    bus.CMD = 2'(cmd);
    bus.ProductID = 4'(id);
    bus.ProductQuantity = 4'(qty);
    got_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.ENABLE = 1'b0;
      if (poke && k == 2 && lat > 3) begin
        bus.ENABLE = 1'b1;
        bus.CMD = 2'b10;
      end
      if (k == 1) check_eq({tag, ".busy1"}, int'(bus.Busy), (lat > 1) ? 1 : 0);
      if (bus.Done || bus.Error) begin
        got_k = k;
        break;
      end
    end
    bus.ENABLE = 1'b0;
    check_eq({tag, ".latency"}, got_k, lat);
    check_eq({tag, ".done"}, int'(bus.Done), (kind == 1) ? 1 : 0);
    check_eq({tag, ".error"}, int'(bus.Error), (kind == 2) ? 1 : 0);
    check_eq({tag, ".busyend"}, int'(bus.Busy), 0);
    check_eq({tag, ".ecode"}, int'(bus.ErrorCode), code);
    extra = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.Done || bus.Error || bus.Busy) extra++;
    end
    check_eq({tag, ".nopulse"}, extra, 0);
    check_eq({tag, ".ecodehold"}, int'(bus.ErrorCode), code);
    check_view(tag);
  endtask

  initial begin
    int r, c, id, q, extra;
    bus.ENABLE = 1'b0;
    bus.CMD = '0;
    bus.ProductID = '0;
    bus.ProductQuantity = '0;
    repeat (3) @(negedge clk);
    bus.ENABLE = 1'b1;
    bus.CMD = 2'b00;
    bus.ProductID = 4'd1;
    bus.ProductQuantity = 4'd1;
    @(negedge clk);
    check_eq("rst.count", int'(item_count), 0);
    check_eq("rst.total", int'(total_price), 0);
    check_eq("rst.busy", int'(bus.Busy), 0);
    check_eq("rst.pulses", int'(bus.Done) + int'(bus.Error), 0);
    check_eq("rst.ecode", int'(bus.ErrorCode), 0);
    check_eq("rst.paddr", int'(price_addr), 0);
    bus.ENABLE = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst.idle", int'(bus.Busy) + int'(bus.Done) + int'(bus.Error), 0);

    run_cmd("add3", 0, 3, 2, 0);
    run_cmd("add5", 0, 5, 1, 0);
    run_cmd("add3sat", 0, 3, 14, 0);
    check_eq("add3sat.total660", int'(total_price), 660);

    run_cmd("clr1", 2, 0, 0, 0);
    for (int i = 0; i < 8; i++) run_cmd($sformatf("fill%0d", i), 0, i, 1, 0);
    run_cmd("full9", 0, 9, 1, 0);
    run_cmd("fullexist", 0, 7, 1, 0);

    run_cmd("clr2", 2, 0, 0, 0);
    run_cmd("b2", 0, 2, 1, 0);
    run_cmd("b4", 0, 4, 2, 0);
    run_cmd("b7", 0, 7, 1, 0);
    run_cmd("rem2", 1, 2, 0, 0);
    run_cmd("rem11", 1, 11, 0, 0);

    run_cmd("inv12", 0, 12, 1, 0);
    run_cmd("invq0", 0, 1, 0, 0);
    run_cmd("invrsv", 3, 1, 1, 0);
    run_cmd("invrem", 1, 14, 0, 0);
    run_cmd("poke", 0, 6, 3, 1);

    // Reset while the command sits in PRICE
    run_cmd("clr3", 2, 0, 0, 0);
    @(negedge clk);
    bus.ENABLE = 1'b1;
    bus.CMD = 2'b00;
    bus.ProductID = 4'd3;
    bus.ProductQuantity = 4'd2;
    @(negedge clk);
    bus.ENABLE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model.delete();
    m_total = 0;
    check_eq("midrst.busy", int'(bus.Busy), 0);
    check_eq("midrst.paddr", int'(price_addr), 0);
    check_eq("midrst.ecode", int'(bus.ErrorCode), 0);
    extra = int'(bus.Done) + int'(bus.Error);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      extra += int'(bus.Done) + int'(bus.Error) + int'(bus.Busy);
    end
    check_eq("midrst.nopulse", extra, 0);
    check_view("midrst");
    run_cmd("clr4", 2, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 19));
      c = (r < 10) ? 0 : (r < 16) ? 1 : (r < 18) ? 2 : 3;
      id = int'($urandom_range(0, 13));
      q = int'($urandom_range(0, 15));
      run_cmd($sformatf("rnd%0d", t), c, id, q, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
